// File: rtl/led_pkg.sv
// Shared types and widths for the LED divider control path.
package led_pkg;

  localparam int DIV_W = 5;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/led_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted rising level. Releases produce no pulse.
module led_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_rise
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [1:0]    r_sync;
  logic          r_deb;
  logic [CW-1:0] r_cnt;
  logic          r_rise;

  // Synchronize the asynchronous button into the clock domain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_btn};
    end
  end

  // Any return to the accepted level restarts the stability count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_deb  <= 1'b0;
      r_cnt  <= '0;
      r_rise <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      if (r_sync[1] != r_deb) begin
        if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
          r_deb  <= r_sync[1];
          r_cnt  <= '0;
          r_rise <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/led_div_ctrl.sv
// Divider control for led_cnt: debounced up/down buttons or an automatic
// ping-pong sweep produce a divider value plus a one-cycle write strobe.
module led_div_ctrl
  import led_pkg::*;
#(
  parameter int               DEBOUNCE_CYC = 1_000_000,
  parameter int               SWEEP_CYC    = 50_000_000,
  parameter logic [DIV_W-1:0] DIV_INIT     = 5'd8,
  parameter logic [DIV_W-1:0] DIV_MIN      = 5'd0,
  parameter logic [DIV_W-1:0] DIV_MAX      = 5'd31
) (
  input  logic             clk100,
  input  logic             rst,
  input  logic             btn_up_i,
  input  logic             btn_dn_i,
  input  logic             auto_en_i,
  output logic [DIV_W-1:0] div_o,
  output logic             wren_o
);

  localparam int TW = (SWEEP_CYC > 2) ? $clog2(SWEEP_CYC) : 1;

  if ((DIV_INIT < DIV_MIN) || (DIV_INIT > DIV_MAX) || (DIV_MIN >= DIV_MAX)) begin : g_bad_bounds
    $error("led_div_ctrl: DIV_INIT must lie in [DIV_MIN, DIV_MAX] with DIV_MIN < DIV_MAX");
  end

  logic             w_rise_up, w_rise_dn, w_tick, w_step;
  logic             w_clr_up, w_clr_dn, w_clr_sw, w_dir_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  state_e           r_state, w_state_nxt;
  logic             r_pend_up, r_pend_dn, r_pend_sw, r_dir_up, r_wren;
  logic [DIV_W-1:0] r_div;
  logic [TW-1:0]    r_tmr;

  led_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
    .i_clk(clk100), .i_rst(rst), .i_btn(btn_up_i), .o_rise(w_rise_up)
  );

  led_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dn (
    .i_clk(clk100), .i_rst(rst), .i_btn(btn_dn_i), .o_rise(w_rise_dn)
  );

  assign w_tick = auto_en_i && (r_tmr == TW'(SWEEP_CYC - 1));

  // Sweep timer and pending requests; a tick is held until IDLE can take it
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_tmr     <= '0;
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
      r_pend_sw <= 1'b0;
    end else if (auto_en_i) begin
      r_tmr     <= w_tick ? '0 : (r_tmr + TW'(1));
      r_pend_up <= 1'b0;
      r_pend_dn <= 1'b0;
      r_pend_sw <= w_tick | (r_pend_sw & ~w_clr_sw);
    end else begin
      r_tmr     <= '0;
      r_pend_up <= w_rise_up | (r_pend_up & ~w_clr_up);
      r_pend_dn <= w_rise_dn | (r_pend_dn & ~w_clr_dn);
      r_pend_sw <= 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT:  w_state_nxt = ST_WRITE;
      ST_IDLE:  w_state_nxt = w_step ? ST_WRITE : ST_IDLE;
      ST_WRITE: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: request servicing, divider step and sweep direction
  always_comb begin
    w_step    = 1'b0;
    w_div_nxt = r_div;
    w_dir_nxt = r_dir_up;
    w_clr_up  = 1'b0;
    w_clr_dn  = 1'b0;
    w_clr_sw  = 1'b0;
    if (r_state == ST_IDLE) begin
      if (auto_en_i) begin
        if (r_pend_sw) begin
          w_clr_sw = 1'b1;
          w_step   = 1'b1;
          if (r_dir_up) begin
            if (r_div < DIV_MAX) begin
              w_div_nxt = r_div + 5'd1;
            end else begin
              w_dir_nxt = 1'b0;
              w_div_nxt = r_div - 5'd1;
            end
          end else begin
            if (r_div > DIV_MIN) begin
              w_div_nxt = r_div - 5'd1;
            end else begin
              w_dir_nxt = 1'b1;
              w_div_nxt = r_div + 5'd1;
            end
          end
        end else begin
          w_step = 1'b0;
        end
      end else if (r_pend_up && r_pend_dn) begin
        w_clr_up = 1'b1;
        w_clr_dn = 1'b1;
      end else if (r_pend_up) begin
        w_clr_up = 1'b1;
        if (r_div < DIV_MAX) begin
          w_step    = 1'b1;
          w_div_nxt = r_div + 5'd1;
        end else begin
          w_step = 1'b0;
        end
      end else if (r_pend_dn) begin
        w_clr_dn = 1'b1;
        if (r_div > DIV_MIN) begin
          w_step    = 1'b1;
          w_div_nxt = r_div - 5'd1;
        end else begin
          w_step = 1'b0;
        end
      end else begin
        w_step = 1'b0;
      end
    end else begin
      w_step = 1'b0;
    end
  end

  // Registered outputs: strobe asserts together with the new divider value
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      r_div    <= DIV_INIT;
      r_dir_up <= 1'b1;
      r_wren   <= 1'b0;
    end else begin
      r_div    <= w_div_nxt;
      r_dir_up <= w_dir_nxt;
      r_wren   <= (w_state_nxt == ST_WRITE);
    end
  end

  assign div_o  = r_div;
  assign wren_o = r_wren;

endmodule

// File: tb/tb_led_div_ctrl.sv
// Self-checking bench for led_div_ctrl: expected writes are queued when
// stimulus is applied and popped whenever the DUT strobes wren_o.
module tb_led_div_ctrl;

  logic       clk100 = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up_i = 1'b0;
  logic       btn_dn_i = 1'b0;
  logic       auto_en_i = 1'b0;
  logic [4:0] div_o;
  logic       wren_o;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         wren_cnt = 0;
  logic [4:0] exp_div = 5'd8;
  logic [4:0] sb[$];

  led_div_ctrl #(
    .DEBOUNCE_CYC(4), .SWEEP_CYC(8), .DIV_INIT(5'd8), .DIV_MIN(5'd0), .DIV_MAX(5'd31)
  ) dut (
    .clk100(clk100), .rst(rst), .btn_up_i(btn_up_i), .btn_dn_i(btn_dn_i),
    .auto_en_i(auto_en_i), .div_o(div_o), .wren_o(wren_o)
  );

  always #5 clk100 = ~clk100;

  // Advance one cycle, sample 1 ns after the edge and score any write strobe
  task automatic tick();
    logic [4:0] exp;
    @(posedge clk100);
    #1;
    cyc++;
    if (wren_o === 1'b1) begin
      wren_cnt++;
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL wren_unexpected: cycle %0d div_o=%0d, no write expected", cyc, div_o);
      end else begin
        exp = sb.pop_front();
        if (div_o !== exp) begin
          n_err++;
          $display("FAIL wren_div: cycle %0d div_o=%0d expected %0d", cyc, div_o, exp);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One clean press: 8 cycles held, 10 cycles released
  task automatic press(input logic up, input logic dn);
    btn_up_i = up;
    btn_dn_i = dn;
    ticks(8);
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    ticks(10);
  endtask

  task automatic press_up_model();
    if (exp_div < 5'd31) begin
      exp_div = exp_div + 5'd1;
      sb.push_back(exp_div);
    end
    press(1'b1, 1'b0);
  endtask

  task automatic press_dn_model();
    if (exp_div > 5'd0) begin
      exp_div = exp_div - 5'd1;
      sb.push_back(exp_div);
    end
    press(1'b0, 1'b1);
  endtask

  task automatic check_drained(input string name);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_missing_wren: %0d writes outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    n_cmp++;
    if (div_o !== exp_div) begin
      n_err++;
      $display("FAIL %s_div: div_o=%0d expected %0d", name, div_o, exp_div);
    end
  endtask

  task automatic test_reset();
    ticks(3);
    n_cmp++;
    if (wren_o !== 1'b0 || div_o !== 5'd8) begin
      n_err++;
      $display("FAIL reset_state: wren_o=%b div_o=%0d expected 0/8", wren_o, div_o);
    end
    exp_div = 5'd8;
    sb.push_back(5'd8);
    rst = 1'b0;
    ticks(2);
    n_cmp++;
    if (wren_cnt != 1) begin
      n_err++;
      $display("FAIL reset_init_pulse: %0d pulses within 2 cycles, expected 1", wren_cnt);
    end
    ticks(6);
    n_cmp++;
    if (wren_cnt != 1) begin
      n_err++;
      $display("FAIL reset_single_pulse: %0d pulses, expected 1", wren_cnt);
    end
    check_drained("reset");
  endtask

  task automatic test_button();
    int c0;
    exp_div = 5'd9;
    sb.push_back(5'd9);
    btn_up_i = 1'b1;
    ticks(10);
    btn_up_i = 1'b0;
    ticks(12);
    check_drained("press_up");
    c0 = wren_cnt;
    for (int g = 0; g < 3; g++) begin
      btn_up_i = 1'b1;
      ticks(3);
      btn_up_i = 1'b0;
      ticks(5);
    end
    ticks(10);
    n_cmp++;
    if (wren_cnt != c0) begin
      n_err++;
      $display("FAIL glitch_pulses: %0d pulses, expected 0", wren_cnt - c0);
    end
    check_drained("glitch");
  endtask

  task automatic test_auto();
    int c0;
    int prev;
    int gaps;
    while (exp_div < 5'd30) press_up_model();
    check_drained("ramp30");
    sb.push_back(5'd31);
    sb.push_back(5'd30);
    sb.push_back(5'd29);
    c0 = wren_cnt;
    prev = -1;
    gaps = 0;
    auto_en_i = 1'b1;
    for (int i = 0; i < 28; i++) begin
      btn_up_i = (i >= 2 && i < 12);
      btn_dn_i = (i >= 4 && i < 14);
      tick();
      if (wren_o === 1'b1) begin
        if (prev >= 0) begin
          gaps++;
          n_cmp++;
          if (cyc - prev != 8) begin
            n_err++;
            $display("FAIL auto_period: gap %0d cycles, expected 8", cyc - prev);
          end
        end
        prev = cyc;
      end
    end
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    n_cmp++;
    if (wren_cnt - c0 != 3 || gaps != 2) begin
      n_err++;
      $display("FAIL auto_count: %0d pulses, expected 3", wren_cnt - c0);
    end
    auto_en_i = 1'b0;
    exp_div = 5'd29;
    ticks(20);
    n_cmp++;
    if (wren_cnt - c0 != 3) begin
      n_err++;
      $display("FAIL auto_drop_write: %0d pulses after auto off, expected 0", wren_cnt - c0 - 3);
    end
    check_drained("auto_hold");
  endtask

  task automatic test_saturation();
    int c0;
    while (exp_div < 5'd31) press_up_model();
    check_drained("ramp31");
    c0 = wren_cnt;
    press(1'b1, 1'b0);
    n_cmp++;
    if (wren_cnt != c0) begin
      n_err++;
      $display("FAIL sat_max_wren: %0d pulses, expected 0", wren_cnt - c0);
    end
    check_drained("sat_max");
    while (exp_div > 5'd0) press_dn_model();
    check_drained("ramp0");
    c0 = wren_cnt;
    press(1'b0, 1'b1);
    n_cmp++;
    if (wren_cnt != c0) begin
      n_err++;
      $display("FAIL sat_min_wren: %0d pulses, expected 0", wren_cnt - c0);
    end
    check_drained("sat_min");
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = wren_cnt;
    press(1'b1, 1'b1);
    n_cmp++;
    if (wren_cnt != c0) begin
      n_err++;
      $display("FAIL simul_wren: %0d pulses, expected 0", wren_cnt - c0);
    end
    check_drained("simul");
    press_up_model();
    check_drained("up_to_1");
    // dn accepted one cycle before up, so up lands while dn's write is in progress
    sb.push_back(5'd0);
    sb.push_back(5'd1);
    exp_div = 5'd1;
    c0 = wren_cnt;
    btn_dn_i = 1'b1;
    tick();
    btn_up_i = 1'b1;
    ticks(8);
    btn_dn_i = 1'b0;
    tick();
    btn_up_i = 1'b0;
    ticks(12);
    n_cmp++;
    if (wren_cnt - c0 != 2) begin
      n_err++;
      $display("FAIL b2b_pulses: %0d pulses, expected 2", wren_cnt - c0);
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_write();
    int  n;
    logic seen;
    sb.push_back(exp_div + 5'd1);
    btn_up_i = 1'b1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = (wren_o === 1'b1);
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL midwrite_timeout: no wren_o within 40 cycles, expected one");
    end
    #1;
    rst = 1'b1;
    btn_up_i = 1'b0;
    #1;
    n_cmp++;
    if (wren_o !== 1'b0 || div_o !== 5'd8) begin
      n_err++;
      $display("FAIL midwrite_async: wren_o=%b div_o=%0d expected 0/8", wren_o, div_o);
    end
    ticks(3);
    sb.delete();
    exp_div = 5'd8;
    sb.push_back(5'd8);
    n = wren_cnt;
    rst = 1'b0;
    ticks(8);
    n_cmp++;
    if (wren_cnt - n != 1) begin
      n_err++;
      $display("FAIL midwrite_reinit: %0d pulses after release, expected 1", wren_cnt - n);
    end
    check_drained("midwrite");
  endtask

  initial begin
    test_reset();
    test_button();
    test_auto();
    test_saturation();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
